pwm_wb8: RTL and testbench
==========================

Name: pwm_wb8

Overview:
- 8-bit Wishbone slave providing up to 4 PWM outputs for the Arduino-compatible headers.
- Sits downstream of the SoC bus arbiter and is decoded at 0xFFFFFAxx; only the low 3 address bits reach the block.
- One shared prescaler and period counter; per-channel duty compare.
- Double-buffered (shadow) period and duty registers, a period-wrap status flag and a level interrupt to the CPU.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..4); duty registers exist at addresses 4..4+CHANNELS-1.

Ports:
- I_wb_clk  input  1  system clock
- I_reset  input  1  asynchronous reset, active-high
- I_wb_adr  input  3  register address
- I_wb_dat  input  8  write data
- I_wb_stb  input  1  bus strobe (already qualified by the arbiter decode)
- I_wb_we  input  1  write enable
- O_wb_dat  output  8  read data
- O_wb_ack  output  1  bus acknowledge
- O_pwm  output  CHANNELS  PWM outputs
- O_interrupt  output  1  level interrupt: wrap flag AND IRQEN

Behaviour:
- Reset (async, active-high) clears all state:
  - All registers 0, shadows 0, prescaler and counter 0.
  - O_pwm=0, O_interrupt=0, O_wb_ack=0, O_wb_dat=0.
- Bus handshake:
  - O_wb_ack is I_wb_stb registered, one-cycle latency, so ack is high the cycle after every stb cycle.
  - A write commits on the clock edge where stb&we is sampled.
  - Read data is registered alongside ack.
  - Unmapped addresses read 0 and ignore writes.
- Register map:
  - 0 CTRL: [0] EN, [1] IRQEN, [2] POL (invert outputs); other bits read 0.
  - 1 PRESC: the counter advances once every PRESC+1 clocks.
  - 2 TOP: the counter runs 0..TOP, so the period is (TOP+1)*(PRESC+1) clocks.
  - 3 STATUS: [0] WRAP; write 1 to clear.
  - 4+n DUTY[n]: compare value for channel n.
- EN=0:
  - Prescaler and counter are held at 0.
  - Shadow TOP and DUTY continuously load from the written registers.
  - O_pwm = {CHANNELS{POL}}.
- EN=1:
  - The prescaler counts 0..PRESC; tick = (prescaler==PRESC).
  - On tick: if counter==shadow TOP, the counter wraps to 0, shadows load from the written registers, and WRAP is set. Otherwise the counter increments.
- Compare: O_pwm[n] is registered as (counter < shadow DUTY[n]) XOR POL, one clock after the counter value.
  - DUTY=0 gives a constant inactive level.
  - DUTY>TOP gives a constant active level.
  - TOP=0 gives a 1-count period.
- Arithmetic: all 8-bit unsigned; the prescaler and counter never exceed their limits. If TOP or PRESC is written smaller than the current count, the current count still finishes at the old shadow value (shadowed).
- Simultaneous WRAP set and W1C clear in the same cycle: set wins.
- Writing EN 1→0 mid-period stops output on the next edge. Re-enable starts at counter 0 with fresh shadows.

Optional Feature:
- PWM_ONESHOT_EN defined:
  - CTRL[3] ONESHOT is writable.
  - When ONESHOT=1, the wrap event also clears EN in the same cycle.
  - The outputs then go to the idle level on the following edge and WRAP is still set.
- PWM_ONESHOT_EN not defined: CTRL[3] reads 0 and writes to it are ignored.

Decomposition:
- Shared package holds:
  - Register address constants (ADR_CTRL=0, ADR_PRESC=1, ADR_TOP=2, ADR_STATUS=3, ADR_DUTY0=4).
  - CTRL bit indices (EN, IRQEN, POL, ONESHOT).
  - STATUS bit index WRAP.
  - Max channel count 4.
- One natural sub-module, pwm_wb8_channel, instantiated CHANNELS times. It holds a per-channel duty shadow register and the compare/polarity/output register, and takes counter, load strobe, EN and POL as inputs.

Test Plan:
- PRESC=0, TOP=9, DUTY0=3, CTRL=0x01 → O_pwm[0] high 3 clocks, low 7, period 10 clocks; WRAP set every 10 clocks.
- PRESC=1, TOP=9, DUTY1=5 → O_pwm[1] high 10 clocks, low 10, period 20 clocks.
- Write DUTY0 3→7 mid-period → current period is still 3 high; next period after wrap is 7 high.
- DUTY2=0 and DUTY3=0xFF with TOP=9 → O_pwm[2] constantly 0, O_pwm[3] constantly 1; set POL=1 → both invert.
- Wrap/IRQ check: IRQEN=1 → O_interrupt rises with WRAP. Write STATUS=0x01 on the wrap cycle → WRAP stays 1. Clear on a later cycle → O_interrupt drops on the next edge.
- Assert I_reset mid-period with outputs high → O_pwm, O_interrupt and all registers read 0 immediately. Bus read of each address after release returns 0 with ack one cycle after stb.

Source files
------------

// File: rtl/pwm_wb8_pkg.sv
// Shared definitions for the pwm_wb8 Wishbone PWM block: register map,
// CTRL/STATUS bit positions and the CTRL register layout.
package pwm_wb8_pkg;

    // Register addresses (low 3 bits of the bus address)
    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_PRESC  = 3'd1;
    localparam logic [2:0] ADR_TOP    = 3'd2;
    localparam logic [2:0] ADR_STATUS = 3'd3;
    localparam logic [2:0] ADR_DUTY0  = 3'd4;

    // CTRL bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQEN   = 1;
    localparam int CTRL_POL     = 2;
    localparam int CTRL_ONESHOT = 3;

    // STATUS bit indices
    localparam int STATUS_WRAP = 0;

    // Duty registers occupy addresses 4..7, so at most four channels fit
    localparam int unsigned MAX_CHANNELS = 4;

    typedef struct packed {
        logic oneshot;
        logic pol;
        logic irqen;
        logic en;
    } ctrl_t;

    // Bus view of CTRL; unused bits read as zero
    function automatic logic [7:0] ctrl_pack(input ctrl_t c);
        logic [7:0] r;
        r               = '0;
        r[CTRL_EN]      = c.en;
        r[CTRL_IRQEN]   = c.irqen;
        r[CTRL_POL]     = c.pol;
        r[CTRL_ONESHOT] = c.oneshot;
        return r;
    endfunction

endpackage

// File: rtl/pwm_wb8_channel.sv
// One PWM channel: duty shadow register plus registered compare output.
// The output is the counter compare XOR polarity, or the idle (polarity)
// level whenever the block is disabled.
module pwm_wb8_channel
    import pwm_wb8_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cnt_i,
    input  logic       load_i,
    input  logic [7:0] duty_i,
    input  logic       en_i,
    input  logic       pol_i,
    output logic       pwm_o
);

    logic [7:0] duty_sh_q, duty_sh_d;
    logic       pwm_q, pwm_d;

    // Next-state: shadow reloads on the load strobe, output follows compare
    always_comb begin
        duty_sh_d = load_i ? duty_i : duty_sh_q;
        pwm_d     = en_i ? ((cnt_i < duty_sh_q) ^ pol_i) : pol_i;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            duty_sh_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_wb8.sv
// pwm_wb8: 8-bit Wishbone slave with up to four PWM outputs sharing one
// prescaler and period counter. TOP, PRESC and DUTY are shadowed and only
// take effect at a period wrap (or continuously while disabled).
// Optional feature macro: PWM_ONESHOT_EN adds CTRL[3] ONESHOT, which clears
// EN on the wrap event.
module pwm_wb8
    import pwm_wb8_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                I_wb_clk,
    input  logic                I_reset,
    input  logic [2:0]          I_wb_adr,
    input  logic [7:0]          I_wb_dat,
    input  logic                I_wb_stb,
    input  logic                I_wb_we,
    output logic [7:0]          O_wb_dat,
    output logic                O_wb_ack,
    output logic [CHANNELS-1:0] O_pwm,
    output logic                O_interrupt
);

    // Programmer-visible registers
    ctrl_t      ctrl_q, ctrl_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] top_q, top_d;
    logic       wrap_q, wrap_d;
    logic [7:0] duty_q [CHANNELS];
    logic [7:0] duty_d [CHANNELS];

    // Shadows and timebase
    logic [7:0] presc_sh_q, presc_sh_d;
    logic [7:0] top_sh_q, top_sh_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [7:0] cnt_q, cnt_d;

    // Bus response
    logic       ack_q;
    logic [7:0] rdat_q, rdat_d;
    logic [7:0] rdata;

    logic wr, rd, tick, wrap_ev, load;

    assign wr      = I_wb_stb & I_wb_we;
    assign rd      = I_wb_stb & ~I_wb_we;
    assign tick    = ctrl_q.en & (pcnt_q == presc_sh_q);
    assign wrap_ev = tick & (cnt_q == top_sh_q);
    // Shadows track the written values while idle, and latch them at each wrap
    assign load    = ~ctrl_q.en | wrap_ev;

    // Register file next-state: bus writes, then wrap event (set beats clear)
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        top_d   = top_q;
        wrap_d  = wrap_q;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            duty_d[n] = duty_q[n];
        end

        if (wr) begin
            case (I_wb_adr)
                ADR_CTRL: begin
                    ctrl_d.en    = I_wb_dat[CTRL_EN];
                    ctrl_d.irqen = I_wb_dat[CTRL_IRQEN];
                    ctrl_d.pol   = I_wb_dat[CTRL_POL];
`ifdef PWM_ONESHOT_EN
                    ctrl_d.oneshot = I_wb_dat[CTRL_ONESHOT];
`endif
                end
                ADR_PRESC: presc_d = I_wb_dat;
                ADR_TOP:   top_d   = I_wb_dat;
                ADR_STATUS: begin
                    if (I_wb_dat[STATUS_WRAP]) begin
                        wrap_d = 1'b0;
                    end
                end
                default: begin
                    for (int n = 0; n < int'(CHANNELS); n++) begin
                        if (I_wb_adr == ADR_DUTY0 + 3'(n)) begin
                            duty_d[n] = I_wb_dat;
                        end
                    end
                end
            endcase
        end

        if (wrap_ev) begin
            wrap_d = 1'b1;
`ifdef PWM_ONESHOT_EN
            if (ctrl_q.oneshot) begin
                ctrl_d.en = 1'b0;
            end
`endif
        end
    end

    // Timebase next-state: prescaler, period counter and shadow reloads
    always_comb begin
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        presc_sh_d = load ? presc_q : presc_sh_q;
        top_sh_d   = load ? top_q : top_sh_q;
        if (!ctrl_q.en) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = (cnt_q == top_sh_q) ? 8'd0 : cnt_q + 8'd1;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rdata = '0;
        case (I_wb_adr)
            ADR_CTRL:   rdata = ctrl_pack(ctrl_q);
            ADR_PRESC:  rdata = presc_q;
            ADR_TOP:    rdata = top_q;
            ADR_STATUS: rdata = {7'b0, wrap_q};
            default: begin
                for (int n = 0; n < int'(CHANNELS); n++) begin
                    if (I_wb_adr == ADR_DUTY0 + 3'(n)) begin
                        rdata = duty_q[n];
                    end
                end
            end
        endcase
        rdat_d = rd ? rdata : 8'h00;
    end

    // All block state, asynchronously cleared
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            ctrl_q     <= '0;
            presc_q    <= '0;
            top_q      <= '0;
            wrap_q     <= 1'b0;
            for (int n = 0; n < int'(CHANNELS); n++) begin
                duty_q[n] <= '0;
            end
            presc_sh_q <= '0;
            top_sh_q   <= '0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            top_q      <= top_d;
            wrap_q     <= wrap_d;
            for (int n = 0; n < int'(CHANNELS); n++) begin
                duty_q[n] <= duty_d[n];
            end
            presc_sh_q <= presc_sh_d;
            top_sh_q   <= top_sh_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            ack_q      <= I_wb_stb;
            rdat_q     <= rdat_d;
        end
    end

    // Per-channel duty shadow and compare output
    for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
        pwm_wb8_channel u_ch (
            .clk_i  (I_wb_clk),
            .rst_i  (I_reset),
            .cnt_i  (cnt_q),
            .load_i (load),
            .duty_i (duty_q[n]),
            .en_i   (ctrl_q.en),
            .pol_i  (ctrl_q.pol),
            .pwm_o  (O_pwm[n])
        );
    end

    assign O_wb_ack    = ack_q;
    assign O_wb_dat    = rdat_q;
    assign O_interrupt = wrap_q & ctrl_q.irqen;

endmodule

// File: tb/tb_pwm_wb8.sv
// Directed self-checking bench for pwm_wb8 (CHANNELS = 4, default build).
// Bus operations start and end on a falling clock edge; the sample index s
// counts falling edges after the enabling write, so s=1 shows counter 0.
module tb_pwm_wb8;
    import pwm_wb8_pkg::*;

    logic       clk      = 1'b0;
    logic       I_reset  = 1'b1;
    logic [2:0] I_wb_adr = '0;
    logic [7:0] I_wb_dat = '0;
    logic       I_wb_stb = 1'b0;
    logic       I_wb_we  = 1'b0;
    logic [7:0] O_wb_dat;
    logic       O_wb_ack;
    logic [3:0] O_pwm;
    logic       O_interrupt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] pat;

    pwm_wb8 #(.CHANNELS(4)) dut (
        .I_wb_clk    (clk),
        .I_reset     (I_reset),
        .I_wb_adr    (I_wb_adr),
        .I_wb_dat    (I_wb_dat),
        .I_wb_stb    (I_wb_stb),
        .I_wb_we     (I_wb_we),
        .O_wb_dat    (O_wb_dat),
        .O_wb_ack    (O_wb_ack),
        .O_pwm       (O_pwm),
        .O_interrupt (O_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; commits on the next rising edge
    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        I_wb_adr = a;
        I_wb_dat = d;
        I_wb_we  = 1'b1;
        I_wb_stb = 1'b1;
        @(negedge clk);
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
    endtask

    // Read with ack/data check after the edge, then one idle cycle
    task automatic wb_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
        I_wb_adr = a;
        I_wb_we  = 1'b0;
        I_wb_stb = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " ack"}, 32'(O_wb_ack), 32'd1);
        chk({tag, " data"}, 32'(O_wb_dat), 32'(exp));
        @(negedge clk);
        I_wb_stb = 1'b0;
        @(negedge clk);
        chk({tag, " ack idle"}, 32'(O_wb_ack), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        I_reset = 1'b1;
        @(negedge clk);
        I_reset = 1'b0;
    endtask

    task automatic capture(input int ch, input int n, output logic [31:0] p);
        p = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p[i] = O_pwm[ch];
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst pwm", 32'(O_pwm), 32'h0);
        chk("rst irq", 32'(O_interrupt), 32'h0);
        chk("rst ack", 32'(O_wb_ack), 32'h0);
        chk("rst dat", 32'(O_wb_dat), 32'h0);
        I_reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), 8'h00, $sformatf("rst rd%0d", a));
        end

        // PRESC=0 TOP=9 DUTY0=3: 3 high, 7 low, period 10
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0, 8'd3);
        wb_write(ADR_CTRL, 8'h01);
        capture(0, 20, pat);
        chk("pwm0 d3", pat, 32'h0001_C07);
        chk("no irq", 32'(O_interrupt), 32'h0);
        wb_read(ADR_STATUS, 8'h01, "wrap set");
        wb_read(ADR_CTRL, 8'h01, "ctrl rb");

        // PRESC=1 TOP=9 DUTY1=5: 10 high, 10 low, period 20
        do_reset();
        wb_write(ADR_PRESC, 8'd1);
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0 + 3'd1, 8'd5);
        wb_write(ADR_CTRL, 8'h01);
        capture(1, 32, pat);
        chk("pwm1 presc1", pat, 32'h3FF0_03FF);

        // DUTY0 3->7 mid-period takes effect only after the wrap
        do_reset();
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0, 8'd3);
        wb_write(ADR_CTRL, 8'h01);
        wb_write(ADR_DUTY0, 8'd7);
        capture(0, 20, pat);
        chk("duty shadow", pat, 32'h0008_FE03);

        // DUTY=0 constant inactive, DUTY>TOP constant active, POL inverts
        do_reset();
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0 + 3'd2, 8'h00);
        wb_write(ADR_DUTY0 + 3'd3, 8'hFF);
        wb_write(ADR_CTRL, 8'h01);
        capture(2, 12, pat);
        chk("duty0 low", pat, 32'h000);
        capture(3, 12, pat);
        chk("dutyFF high", pat, 32'hFFF);
        wb_write(ADR_CTRL, 8'h05);
        capture(2, 12, pat);
        chk("pol duty0", pat, 32'hFFF);
        capture(3, 12, pat);
        chk("pol dutyFF", pat, 32'h000);
        // Disable: idle level (POL) on the next edge
        wb_write(ADR_CTRL, 8'h04);
        @(negedge clk);
        chk("disable idle", 32'(O_pwm[3:2]), 32'h3);
        wb_write(ADR_CTRL, 8'h0E);
`ifdef PWM_ONESHOT_EN
        wb_read(ADR_CTRL, 8'h0E, "ctrl bit3");
`else
        wb_read(ADR_CTRL, 8'h06, "ctrl bit3");
`endif

        // Wrap flag and interrupt; set beats a simultaneous clear
        do_reset();
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0, 8'd3);
        wb_write(ADR_CTRL, 8'h03);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = O_interrupt;
        end
        chk("irq rise", pat, 32'h200);
        wb_write(ADR_STATUS, 8'h01);          // s=10 -> commit before counter 1
        chk("irq clear", 32'(O_interrupt), 32'h0);
        repeat (8) @(negedge clk);            // s=19, counter at 9
        chk("irq still clear", 32'(O_interrupt), 32'h0);
        wb_write(ADR_STATUS, 8'h01);          // commit on the wrap edge
        chk("set wins", 32'(O_interrupt), 32'h1);
        wb_read(ADR_STATUS, 8'h01, "wrap kept");
        wb_write(ADR_STATUS, 8'h01);
        chk("irq drop", 32'(O_interrupt), 32'h0);

        // Asynchronous reset mid-period with outputs high
        do_reset();
        wb_write(ADR_TOP, 8'd9);
        wb_write(ADR_DUTY0, 8'd3);
        wb_write(ADR_CTRL, 8'h03);
        repeat (11) @(negedge clk);
        chk("pre-rst pwm", 32'(O_pwm[0]), 32'h1);
        chk("pre-rst irq", 32'(O_interrupt), 32'h1);
        #2;
        I_reset = 1'b1;
        #1;
        chk("async pwm", 32'(O_pwm), 32'h0);
        chk("async irq", 32'(O_interrupt), 32'h0);
        chk("async ack", 32'(O_wb_ack), 32'h0);
        chk("async dat", 32'(O_wb_dat), 32'h0);
        @(negedge clk);
        I_reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), 8'h00, $sformatf("post rd%0d", a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
